// File: rtl/pipe_hazard_ctrl.sv
// ID-stage pipeline controller: decode, registered ID/EX bundle, hazard stalls, flush and power-up hold.
// Optional HAZARD_STATS_EN adds saturating stall_cnt / flush_cnt statistics outputs.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int INIT_CYCLES = 1,
    parameter int BR_LD_STALL = 2,
    parameter int STAT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            func,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  eq,
    output logic                  pc_en,
    output logic [1:0]            pc_sel,
    output logic                  ifid_en,
    output logic                  ifid_clr,
    output logic                  ex_reg_dst,
    output logic                  ex_alu_src,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_reg_write,
    output logic                  ex_jal,
    output logic [2:0]            ex_alu_ctl,
    output logic [REG_ADDR_W-1:0] ex_dst
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0]     stall_cnt,
    output logic [STAT_W-1:0]     flush_cnt
`endif
);

    // state   | meaning
    // S_INIT  | power-up hold, PC frozen, bubbles into ID/EX
    // S_RUN   | normal decode with hazard checks and redirects
    // S_STALL | extra stall cycles for a branch/jr waiting on a load
    typedef enum logic [1:0] {S_INIT, S_RUN, S_STALL} state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    localparam logic [3:0] INIT_RELOAD = 4'(INIT_CYCLES - 1);
    localparam bit         BR_MULTI    = (BR_LD_STALL > 1);
    localparam logic [2:0] BR_RELOAD   = BR_MULTI ? 3'(BR_LD_STALL - 2) : 3'd0;

    state_t state, nxt_state;
    logic [3:0] init_cnt;
    logic [2:0] st_cnt;

    logic d_reg_dst, d_alu_src, d_mem_read, d_mem_write, d_mem_to_reg, d_reg_write, d_jal;
    logic [2:0] d_alu_ctl;
    logic [REG_ADDR_W-1:0] d_dst;
    logic rd_rs, rd_rt, is_br, is_jr, is_j;

    always_comb begin
        d_reg_dst    = 1'b0;
        d_alu_src    = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_to_reg = 1'b0;
        d_reg_write  = 1'b0;
        d_jal        = 1'b0;
        d_alu_ctl    = 3'b000;
        rd_rs        = 1'b0;
        rd_rt        = 1'b0;
        is_br        = 1'b0;
        is_jr        = 1'b0;
        is_j         = 1'b0;
        case (opcode)
            OP_R: begin
                rd_rs       = 1'b1;
                rd_rt       = 1'b1;
                d_reg_dst   = 1'b1;
                d_reg_write = 1'b1;
                case (func)
                    FN_ADD: d_alu_ctl = 3'b010;
                    FN_SUB: d_alu_ctl = 3'b110;
                    FN_AND: d_alu_ctl = 3'b000;
                    FN_OR:  d_alu_ctl = 3'b001;
                    FN_SLT: d_alu_ctl = 3'b111;
                    FN_JR: begin
                        d_reg_dst   = 1'b0;
                        d_reg_write = 1'b0;
                        rd_rt       = 1'b0;
                        is_jr       = 1'b1;
                    end
                    default: begin
                        d_alu_ctl   = 3'b101;
                        d_reg_write = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                rd_rs        = 1'b1;
                d_alu_src    = 1'b1;
                d_mem_read   = 1'b1;
                d_mem_to_reg = 1'b1;
                d_reg_write  = 1'b1;
                d_alu_ctl    = 3'b010;
            end
            OP_SW: begin
                rd_rs       = 1'b1;
                rd_rt       = 1'b1;
                d_alu_src   = 1'b1;
                d_mem_write = 1'b1;
                d_alu_ctl   = 3'b010;
            end
            OP_ADDI, OP_SLTI: begin
                rd_rs       = 1'b1;
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
                d_alu_ctl   = (opcode == OP_SLTI) ? 3'b111 : 3'b010;
            end
            OP_BEQ, OP_BNE: begin
                rd_rs     = 1'b1;
                rd_rt     = 1'b1;
                is_br     = 1'b1;
                d_alu_ctl = 3'b110;
            end
            OP_J: is_j = 1'b1;
            OP_JAL: begin
                is_j        = 1'b1;
                d_reg_write = 1'b1;
                d_jal       = 1'b1;
            end
            default: ;
        endcase
    end

    // Non-writing instructions carry dst=0 so they can never look like a producer.
    always_comb begin
        if (!d_reg_write)   d_dst = '0;
        else if (d_jal)     d_dst = REG_ADDR_W'(31);
        else if (d_reg_dst) d_dst = id_rd;
        else                d_dst = id_rt;
    end

    logic ex_live, opnd_hit, br_like, haz_br_ld, stall_run;
    logic br_taken, redirect, load_bundle;
    logic [1:0] redir_sel;

    always_comb begin
        ex_live   = ex_reg_write && (ex_dst != '0);
        opnd_hit  = ex_live && ((rd_rs && id_rs == ex_dst) || (rd_rt && id_rt == ex_dst));
        br_like   = is_br || is_jr;
        haz_br_ld = br_like && opnd_hit && ex_mem_read;
        stall_run = opnd_hit && (br_like || ex_mem_read);
        br_taken  = (opcode == OP_BEQ && eq) || (opcode == OP_BNE && !eq);
        if (br_taken)   redir_sel = PC_BR;
        else if (is_j)  redir_sel = PC_JMP;
        else if (is_jr) redir_sel = PC_JR;
        else            redir_sel = PC_SEQ;
        redirect  = (redir_sel != PC_SEQ);
    end

    always_comb begin
        nxt_state   = state;
        pc_en       = 1'b0;
        pc_sel      = PC_SEQ;
        ifid_en     = 1'b0;
        ifid_clr    = 1'b0;
        load_bundle = 1'b0;
        case (state)
            S_INIT: if (init_cnt == 4'd0) nxt_state = S_RUN;
            S_RUN: begin
                if (stall_run) begin
                    if (haz_br_ld && BR_MULTI) nxt_state = S_STALL;
                end else begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    pc_sel      = redir_sel;
                    ifid_clr    = redirect;
                    load_bundle = !redirect || d_jal;
                end
            end
            S_STALL: if (st_cnt == 3'd0) nxt_state = S_RUN;
            default: nxt_state = S_INIT;
        endcase
        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            ifid_clr = 1'b1;
            pc_sel   = PC_SEQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_INIT;
            init_cnt      <= INIT_RELOAD;
            st_cnt        <= BR_RELOAD;
            ex_reg_dst    <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_jal        <= 1'b0;
            ex_alu_ctl    <= 3'b000;
            ex_dst        <= '0;
        end else begin
            state <= nxt_state;
            if (state == S_INIT && init_cnt != 4'd0) init_cnt <= init_cnt - 4'd1;
            if (state == S_RUN && nxt_state == S_STALL) st_cnt <= BR_RELOAD;
            else if (state == S_STALL && st_cnt != 3'd0) st_cnt <= st_cnt - 3'd1;
            ex_reg_dst    <= load_bundle && d_reg_dst;
            ex_alu_src    <= load_bundle && d_alu_src;
            ex_mem_read   <= load_bundle && d_mem_read;
            ex_mem_write  <= load_bundle && d_mem_write;
            ex_mem_to_reg <= load_bundle && d_mem_to_reg;
            ex_reg_write  <= load_bundle && d_reg_write;
            ex_jal        <= load_bundle && d_jal;
            ex_alu_ctl    <= load_bundle ? d_alu_ctl : 3'b000;
            ex_dst        <= load_bundle ? d_dst : '0;
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    logic stall_cyc;
    assign stall_cyc = (state == S_STALL) || (state == S_RUN && stall_run);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_cyc && stall_cnt != STAT_MAX) stall_cnt <= stall_cnt + STAT_W'(1);
            if (ifid_clr && flush_cnt != STAT_MAX) flush_cnt <= flush_cnt + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle-level reference model queues expected outputs,
// two monitors pop and compare the combinational controls and the registered ID/EX bundle.
module tb_pipe_hazard_ctrl;
    localparam int RW     = 5;
    localparam int INIT_C = 1;
    localparam int BRS    = 2;
`ifdef HAZARD_STATS_EN
    localparam int SW     = 2;
`else
    localparam int SW     = 16;
`endif
    localparam int SMAX   = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] opcode = '0, func = '0;
    logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic eq = 1'b0;
    logic pc_en, ifid_en, ifid_clr;
    logic [1:0] pc_sel;
    logic ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_jal;
    logic [2:0] ex_alu_ctl;
    logic [RW-1:0] ex_dst;
`ifdef HAZARD_STATS_EN
    logic [SW-1:0] stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl #(
        .REG_ADDR_W(RW), .INIT_CYCLES(INIT_C), .BR_LD_STALL(BRS), .STAT_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .eq(eq),
        .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en), .ifid_clr(ifid_clr),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_jal(ex_jal), .ex_alu_ctl(ex_alu_ctl), .ex_dst(ex_dst)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0]  q_comb[$];
    logic [14:0] q_ex[$];
    int          q_sc[$];
    int          q_fc[$];

    // Model state: bundle as {reg_dst,alu_src,mem_read,mem_write,mem_to_reg,reg_write,jal,alu_ctl,dst}.
    logic [14:0] m_ex = '0;
    int m_init = INIT_C, m_stall = 0, m_sc = 0, m_fc = 0;
    bit m_ifid_en = 1'b0;

    function automatic logic [14:0] ref_bundle(input logic [5:0] op, input logic [5:0] fn,
                                               input logic [4:0] rt, input logic [4:0] rd);
        logic rdst = 0, asrc = 0, mr = 0, mw = 0, m2r = 0, rw = 0, jl = 0;
        logic [2:0] alu = 3'd0;
        logic [4:0] dst;
        case (op)
            6'd0: begin
                rdst = 1; rw = 1;
                case (fn)
                    6'd32: alu = 3'd2;
                    6'd34: alu = 3'd6;
                    6'd36: alu = 3'd0;
                    6'd37: alu = 3'd1;
                    6'd42: alu = 3'd7;
                    6'd8:  begin rdst = 0; rw = 0; end
                    default: begin alu = 3'd5; rw = 0; end
                endcase
            end
            6'd35: begin asrc = 1; mr = 1; m2r = 1; rw = 1; alu = 3'd2; end
            6'd43: begin asrc = 1; mw = 1; alu = 3'd2; end
            6'd8:  begin asrc = 1; rw = 1; alu = 3'd2; end
            6'd10: begin asrc = 1; rw = 1; alu = 3'd7; end
            6'd4, 6'd5: alu = 3'd6;
            6'd3:  begin rw = 1; jl = 1; end
            default: ;
        endcase
        dst = !rw ? 5'd0 : jl ? 5'd31 : rdst ? rd : rt;
        return {rdst, asrc, mr, mw, m2r, rw, jl, alu, dst};
    endfunction

    function automatic int sat(input int v);
        return (v < SMAX) ? v + 1 : v;
    endfunction

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic e, input logic r);
        logic [4:0]  c;
        logic [14:0] nx;
        logic [1:0]  sel;
        bit urs, urt, hit, br;
        @(negedge clk);
        opcode = op; func = fn; id_rs = rs; id_rt = rt; id_rd = rd; eq = e; rst = r;
        if (r) begin
            c = 5'b0_00_0_1; nx = '0;
            m_init = INIT_C; m_stall = 0; m_sc = 0; m_fc = 0;
        end else if (m_init > 0) begin
            c = '0; nx = '0; m_init--;
        end else if (m_stall > 0) begin
            c = '0; nx = '0; m_stall--; m_sc = sat(m_sc);
        end else begin
            urs = (op == 0) || op == 35 || op == 43 || op == 8 || op == 10 || op == 4 || op == 5;
            urt = (op == 0 && fn != 8) || op == 43 || op == 4 || op == 5;
            hit = m_ex[9] && m_ex[4:0] != 0 &&
                  ((urs && rs == m_ex[4:0]) || (urt && rt == m_ex[4:0]));
            br  = op == 4 || op == 5 || (op == 0 && fn == 8);
            if (hit && (br || m_ex[12])) begin
                c = '0; nx = '0; m_sc = sat(m_sc);
                if (br && m_ex[12]) m_stall = BRS - 1;
            end else begin
                if ((op == 4 && e) || (op == 5 && !e)) sel = 2'd1;
                else if (op == 2 || op == 3)           sel = 2'd2;
                else if (op == 0 && fn == 8)           sel = 2'd3;
                else                                   sel = 2'd0;
                c  = {1'b1, sel, 1'b1, sel != 0};
                nx = (sel == 0 || op == 3) ? ref_bundle(op, fn, rt, rd) : '0;
                if (sel != 0) m_fc = sat(m_fc);
            end
        end
        m_ex = nx;
        m_ifid_en = c[1];
        q_comb.push_back(c);
        q_ex.push_back(nx);
        q_sc.push_back(m_sc);
        q_fc.push_back(m_fc);
    endtask

    // Present one instruction, holding it in ID while the pipeline stalls.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic e);
        int n = 0;
        do begin
            step(op, fn, rs, rt, rd, e, 1'b0);
            n++;
        end while (!m_ifid_en && n < 20);
        if (!m_ifid_en) begin
            n_checks++;
            $display("FAIL issue_bound: instruction op=%0d still held after %0d cycles, need ifid_en=1", op, n);
        end
    endtask

    always begin
        logic [4:0] got, exp;
        @(negedge clk);
        #2;
        if (q_comb.size() > 0) begin
            exp = q_comb.pop_front();
            got = {pc_en, pc_sel, ifid_en, ifid_clr};
            n_checks++;
            if (got !== exp)
                $display("FAIL comb @%0t: pc_en/pc_sel/ifid_en/ifid_clr got %b/%b/%b/%b need %b/%b/%b/%b",
                         $time, got[4], got[3:2], got[1], got[0], exp[4], exp[3:2], exp[1], exp[0]);
            else n_pass++;
        end
    end

    always begin
        logic [14:0] got, exp;
        int esc, efc;
        @(posedge clk);
        #1;
        if (q_ex.size() > 0) begin
            exp = q_ex.pop_front();
            esc = q_sc.pop_front();
            efc = q_fc.pop_front();
            got = {ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                   ex_reg_write, ex_jal, ex_alu_ctl, ex_dst};
            n_checks++;
            if (got !== exp)
                $display("FAIL idex @%0t: bundle got %b alu=%b dst=%0d need %b alu=%b dst=%0d",
                         $time, got[14:8], got[7:5], got[4:0], exp[14:8], exp[7:5], exp[4:0]);
            else n_pass++;
`ifdef HAZARD_STATS_EN
            n_checks++;
            if (int'(stall_cnt) != esc || int'(flush_cnt) != efc)
                $display("FAIL stats @%0t: stall_cnt=%0d flush_cnt=%0d need %0d/%0d",
                         $time, stall_cnt, flush_cnt, esc, efc);
            else n_pass++;
`else
            if (esc < 0 || efc < 0) $display("note: negative model count");
`endif
        end
    end

    logic [5:0] ops[11] = '{6'd0, 6'd0, 6'd35, 6'd43, 6'd8, 6'd10, 6'd4, 6'd5, 6'd2, 6'd3, 6'd63};
    logic [5:0] fns[7]  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd8, 6'd13};

    initial begin
        step(0, 0, 0, 0, 0, 0, 1'b1);
        step(0, 0, 0, 0, 0, 0, 1'b1);
        // Power-up hold then lw $2 ; add $3,$2,$4 (load-use)
        issue(6'd35, 0, 5'd1, 5'd2, 5'd0, 0);
        issue(6'd0, 6'd32, 5'd2, 5'd4, 5'd3, 0);
        // Branch on ALU result, then lw $5 ; beq $5,$6 taken
        issue(6'd4, 0, 5'd3, 5'd6, 5'd0, 0);
        issue(6'd35, 0, 5'd1, 5'd5, 5'd0, 0);
        issue(6'd4, 0, 5'd5, 5'd6, 5'd0, 1);
        issue(6'd3, 0, 5'd0, 5'd0, 5'd0, 0);
        issue(6'd0, 6'd13, 5'd0, 5'd0, 5'd0, 0);
        issue(6'd0, 6'd8, 5'd0, 5'd0, 5'd0, 0);
        // Reset aborting a branch-on-load stall, then an INIT abort
        issue(6'd35, 0, 5'd1, 5'd7, 5'd0, 0);
        step(6'd5, 0, 5'd7, 5'd1, 5'd0, 0, 1'b0);
        step(6'd5, 0, 5'd7, 5'd1, 5'd0, 0, 1'b1);
        step(6'd5, 0, 5'd7, 5'd1, 5'd0, 0, 1'b0);
        step(6'd5, 0, 5'd7, 5'd1, 5'd0, 0, 1'b1);
        // Five load-use stalls to push the stall counter to saturation
        for (int i = 0; i < 5; i++) begin
            issue(6'd35, 0, 5'd0, 5'd2, 5'd0, 0);
            issue(6'd43, 0, 5'd1, 5'd2, 5'd0, 0);
        end
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                step(0, 0, 0, 0, 0, 0, 1'b1);
            end else begin
                issue(ops[$urandom_range(0, 10)], fns[$urandom_range(0, 6)],
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
        end
        repeat (3) @(negedge clk);
        #3;
        n_checks++;
        if (q_comb.size() != 0 || q_ex.size() != 0)
            $display("FAIL drain: %0d/%0d expectations left, need 0/0", q_comb.size(), q_ex.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
